// File: rtl/quat_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : quat_mult_pipe
//  Description : Pops quaternion operand pairs (a in lanes 0-3, b in lanes
//                4-7) from an upstream FIFO, computes the Hamilton product
//                r = a*b in signed fixed point through a 4-cycle pipeline,
//                and queues results in a small valid/ready output buffer.
//                Pops are issued against credits, so the pipeline never
//                stalls. Optional macro QMULT_SAT_STATUS_EN adds a sticky
//                saturation flag (sat_sticky) with a clear input (clr_status).
//                reset_n is asserted asynchronously. Its release is assumed
//                to be synchronised to clk outside this block.
//  Revision    : 1.0 - initial release
// ============================================================================
module quat_mult_pipe #(
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_d0,
    input  logic [DATA_W-1:0] fifo_d1,
    input  logic [DATA_W-1:0] fifo_d2,
    input  logic [DATA_W-1:0] fifo_d3,
    input  logic [DATA_W-1:0] fifo_d4,
    input  logic [DATA_W-1:0] fifo_d5,
    input  logic [DATA_W-1:0] fifo_d6,
    input  logic [DATA_W-1:0] fifo_d7,
    output logic [DATA_W-1:0] res0,
    output logic [DATA_W-1:0] res1,
    output logic [DATA_W-1:0] res2,
    output logic [DATA_W-1:0] res3,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
`ifdef QMULT_SAT_STATUS_EN
    ,
    output logic              sat_sticky,
    input  logic              clr_status
`endif
);

    localparam int c_prod_w = 2 * DATA_W;
    localparam int c_sum_w  = 2 * DATA_W + 2;
    localparam int c_ptr_w  = $clog2(OUT_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;

    localparam logic [c_cnt_w:0]         c_depth = (c_cnt_w + 1)'(OUT_DEPTH);
    localparam logic signed [c_sum_w-1:0] c_half  = {{(c_sum_w-1){1'b0}}, 1'b1} << (FRAC_W - 1);
    localparam logic signed [c_sum_w-1:0] c_max   = {{(c_sum_w-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [c_sum_w-1:0] c_min   = {{(c_sum_w-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]         c_one   = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;

    // Sign-extend a product to the accumulation width (two guard bits).
    function automatic logic signed [c_sum_w-1:0] sx(input logic signed [c_prod_w-1:0] p);
        return {{2{p[c_prod_w-1]}}, p};
    endfunction

    logic [DATA_W-1:0]          w_fifo_d [8];
    logic                       r_v0;
    logic                       r_s0_v;
    logic                       r_s1_v;
    logic signed [DATA_W-1:0]   r_a [4];
    logic signed [DATA_W-1:0]   r_b [4];
    logic signed [c_prod_w-1:0] r_p [16];
    logic signed [c_sum_w-1:0]  w_sum [4];
    logic signed [c_sum_w-1:0]  w_rnd [4];
    logic signed [c_sum_w-1:0]  w_shr [4];
    logic [DATA_W-1:0]          w_res [4];
    logic [4*DATA_W-1:0]        w_result;

    logic [4*DATA_W-1:0]        r_mem [OUT_DEPTH];
    logic [c_ptr_w-1:0]         r_wr_ptr;
    logic [c_ptr_w-1:0]         r_rd_ptr;
    logic [c_cnt_w-1:0]         r_count;
    logic [c_cnt_w-1:0]         r_inflight;
    logic [4*DATA_W-1:0]        r_last;
    logic [4*DATA_W-1:0]        w_head;
    logic [4*DATA_W-1:0]        w_out;
    logic [c_cnt_w:0]           w_credit;
    logic                       w_wr;
    logic                       w_rd;

    assign w_fifo_d[0] = fifo_d0;
    assign w_fifo_d[1] = fifo_d1;
    assign w_fifo_d[2] = fifo_d2;
    assign w_fifo_d[3] = fifo_d3;
    assign w_fifo_d[4] = fifo_d4;
    assign w_fifo_d[5] = fifo_d5;
    assign w_fifo_d[6] = fifo_d6;
    assign w_fifo_d[7] = fifo_d7;

    // A pop is issued only when a buffer slot is guaranteed for its result.
    assign w_credit   = {1'b0, r_inflight} + {1'b0, r_count};
    assign fifo_rd_en = reset_n && enable && !fifo_empty && (w_credit < c_depth);

    assign res_valid = (r_count != '0);
    assign busy      = (r_inflight != '0) || (r_count != '0);
    assign w_wr      = r_s1_v;
    assign w_rd      = res_valid && res_ready;

    // Pipeline valid chain: pop -> FIFO data valid -> S0 -> S1 (S2 writes).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v0   <= 1'b0;
            r_s0_v <= 1'b0;
            r_s1_v <= 1'b0;
        end else begin
            r_v0   <= fifo_rd_en;
            r_s0_v <= r_v0;
            r_s1_v <= r_s0_v;
        end
    end

    // Datapath registers: capture operands, then all 16 full-width products.
    always_ff @(posedge clk) begin
        if (r_v0) begin
            for (int i = 0; i < 4; i++) begin
                r_a[i] <= $signed(w_fifo_d[i]);
                r_b[i] <= $signed(w_fifo_d[i+4]);
            end
        end
        if (r_s0_v) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_p[i*4+j] <= c_prod_w'(r_a[i]) * c_prod_w'(r_b[j]);
                end
            end
        end
    end

    // Hamilton sums (index i*4+j holds a_i*b_j), round half up, saturate.
    always_comb begin
        w_sum[0] = sx(r_p[0]) - sx(r_p[5])  - sx(r_p[10]) - sx(r_p[15]);
        w_sum[1] = sx(r_p[1]) + sx(r_p[4])  + sx(r_p[11]) - sx(r_p[14]);
        w_sum[2] = sx(r_p[2]) - sx(r_p[7])  + sx(r_p[8])  + sx(r_p[13]);
        w_sum[3] = sx(r_p[3]) + sx(r_p[6])  - sx(r_p[9])  + sx(r_p[12]);
        for (int k = 0; k < 4; k++) begin
            w_rnd[k] = w_sum[k] + c_half;
            w_shr[k] = w_rnd[k] >>> FRAC_W;
            if (w_shr[k] > c_max) begin
                w_res[k] = {1'b0, {(DATA_W-1){1'b1}}};
            end else if (w_shr[k] < c_min) begin
                w_res[k] = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                w_res[k] = w_shr[k][DATA_W-1:0];
            end
        end
        w_result = {w_res[3], w_res[2], w_res[1], w_res[0]};
    end

    // Result storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    // Buffer pointers, occupancy, in-flight credits and last-read value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_last     <= {{(3*DATA_W){1'b0}}, c_one};
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                r_last   <= w_head;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            case ({fifo_rd_en, w_wr})
                2'b10:   r_inflight <= r_inflight + c_cnt_w'(1);
                2'b01:   r_inflight <= r_inflight - c_cnt_w'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Empty buffer shows the most recently consumed result (identity after reset).
    assign w_head = r_mem[r_rd_ptr];
    assign w_out  = res_valid ? w_head : r_last;
    assign res0   = w_out[DATA_W-1:0];
    assign res1   = w_out[2*DATA_W-1:DATA_W];
    assign res2   = w_out[3*DATA_W-1:2*DATA_W];
    assign res3   = w_out[4*DATA_W-1:3*DATA_W];

`ifdef QMULT_SAT_STATUS_EN
    logic w_sat_any;

    // Flag whether any component of the result being written was clamped.
    always_comb begin
        w_sat_any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((w_shr[k] > c_max) || (w_shr[k] < c_min)) w_sat_any = 1'b1;
        end
    end

    // Sticky saturation status; a new saturation beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_sticky <= 1'b0;
        end else if (r_s1_v && w_sat_any) begin
            sat_sticky <= 1'b1;
        end else if (clr_status) begin
            sat_sticky <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire
